// File: rtl/yin_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : yin_frontend_if
// Brief    : ADC-side and detector-side signal bundle of the YIN front end.
// Revision : 1.0
// ============================================================================
interface yin_frontend_if #(
    parameter int IN_WIDTH   = 12,
    parameter int SIG_WIDTH  = 9,
    parameter int FIFO_DEPTH = 64
);
    logic [IN_WIDTH-1:0]           adc_in;
    logic                          adc_in_valid;
    logic                          pitch_valid_in;
    logic [SIG_WIDTH-1:0]          sig_out;
    logic                          sig_out_valid;
    logic                          start_computation_out;
    logic                          overflow_out;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_out;

    modport master (
        input  adc_in, adc_in_valid, pitch_valid_in,
        output sig_out, sig_out_valid, start_computation_out,
               overflow_out, fifo_level_out
    );

    modport slave (
        output adc_in, adc_in_valid, pitch_valid_in,
        input  sig_out, sig_out_valid, start_computation_out,
               overflow_out, fifo_level_out
    );
endinterface
`default_nettype wire

// File: rtl/yin_frontend.sv
`default_nettype none
// ============================================================================
// Module   : yin_frontend
// Brief    : Boxcar decimator, sample FIFO and hop framing for the YIN
//            detector. Define FRONTEND_DC_BLOCK_EN for tracked DC removal.
// Revision : 1.0
// ============================================================================
module yin_frontend #(
    parameter int IN_WIDTH    = 12,
    parameter int SIG_WIDTH   = 9,
    parameter int DECIM       = 4,
    parameter int WINDOW_SIZE = 500,
    parameter int HOP         = 250,
    parameter int FIFO_DEPTH  = 64
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    yin_frontend_if.master   fe
);
    localparam int c_LOG2_DECIM = $clog2(DECIM);
    localparam int c_ACC_W      = IN_WIDTH + c_LOG2_DECIM;
    localparam int c_AW         = $clog2(FIFO_DEPTH);
    localparam int c_SHIFT      = IN_WIDTH - SIG_WIDTH;
    localparam int c_CNT_MAX    = (WINDOW_SIZE > HOP) ? WINDOW_SIZE : HOP;
    localparam int c_CNT_W      = $clog2(c_CNT_MAX + 1);

    localparam logic signed [IN_WIDTH:0] c_MIDSCALE    = (IN_WIDTH+1)'(1) << (IN_WIDTH-1);
    localparam logic [c_LOG2_DECIM-1:0]  c_LAST_PHASE  = c_LOG2_DECIM'(DECIM - 1);
    localparam logic [c_AW:0]            c_FULL_LVL    = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]       c_WINDOW      = c_CNT_W'(WINDOW_SIZE);
    localparam logic [c_CNT_W-1:0]       c_HOP         = c_CNT_W'(HOP);

    typedef enum logic [1:0] {
        S_FILL        = 2'd0,
        S_RUN         = 2'd1,
        S_WAIT_RESULT = 2'd2,
        S_START       = 2'd3
    } state_t;

    // ---------------- decimator ----------------
    logic [c_ACC_W-1:0]      r_acc;
    logic [c_LOG2_DECIM-1:0] r_phase;
    logic                    r_push;
    logic [SIG_WIDTH-1:0]    r_push_data;

    logic [c_ACC_W-1:0]      w_sum;
    logic [IN_WIDTH-1:0]     w_mean;
    logic signed [IN_WIDTH:0] w_centered;
    logic [SIG_WIDTH-1:0]    w_sample;

    assign w_sum  = r_acc + c_ACC_W'(fe.adc_in);
    assign w_mean = IN_WIDTH'(w_sum >> c_LOG2_DECIM);

`ifdef FRONTEND_DC_BLOCK_EN
    // DC estimate carries 6 fractional bits; output uses the pre-update estimate
    localparam logic [IN_WIDTH+5:0] c_DC_INIT = {c_MIDSCALE[IN_WIDTH-1:0], 6'b0};

    logic [IN_WIDTH+5:0]        r_dc;
    logic signed [IN_WIDTH+7:0] w_dc_err;

    assign w_dc_err   = $signed({2'b00, w_mean, 6'b0}) - $signed({2'b00, r_dc});
    assign w_centered = $signed({1'b0, w_mean}) - $signed({1'b0, r_dc[IN_WIDTH+5:6]});

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_dc <= c_DC_INIT;
        end else if (fe.adc_in_valid && (r_phase == c_LAST_PHASE)) begin
            r_dc <= r_dc + (IN_WIDTH+6)'(w_dc_err >>> 6);
        end
    end
`else
    assign w_centered = $signed({1'b0, w_mean}) - c_MIDSCALE;
`endif

    assign w_sample = SIG_WIDTH'(w_centered >>> c_SHIFT);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc       <= '0;
            r_phase     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (fe.adc_in_valid) begin
                if (r_phase == c_LAST_PHASE) begin
                    r_acc       <= '0;
                    r_phase     <= '0;
                    r_push      <= 1'b1;
                    r_push_data <= w_sample;
                end else begin
                    r_acc   <= w_sum;
                    r_phase <= r_phase + 1'b1;
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [SIG_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_level;
    logic                 r_overflow;
    state_t               r_state;

    logic w_pop;
    logic w_push;

    assign w_pop  = ((r_state == S_FILL) || (r_state == S_RUN)) && (r_level != '0);
    assign w_push = r_push && ((r_level != c_FULL_LVL) || w_pop);

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
            if (r_push && !w_push)     r_overflow <= 1'b1;
        end
    end

    // ---------------- framing FSM ----------------
    logic [c_CNT_W-1:0]   r_sent_cnt;
    logic [SIG_WIDTH-1:0] r_sig_out;
    logic                 r_sig_valid;
    logic                 r_start;

    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_CNT_W-1:0] w_limit;

    assign w_cnt_inc = r_sent_cnt + 1'b1;
    assign w_limit   = (r_state == S_FILL) ? c_WINDOW : c_HOP;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_FILL;
            r_sent_cnt  <= '0;
            r_sig_out   <= '0;
            r_sig_valid <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            r_sig_valid <= 1'b0;
            r_start     <= 1'b0;
            case (r_state)
                S_FILL, S_RUN: begin
                    if (w_pop) begin
                        r_sig_out   <= r_mem[r_rd_ptr];
                        r_sig_valid <= 1'b1;
                        r_sent_cnt  <= w_cnt_inc;
                        if (w_cnt_inc == w_limit) r_state <= S_START;
                    end
                end
                S_START: begin
                    r_start    <= 1'b1;
                    r_sent_cnt <= '0;
                    r_state    <= S_WAIT_RESULT;
                end
                S_WAIT_RESULT: begin
                    if (fe.pitch_valid_in) r_state <= S_RUN;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign fe.sig_out               = r_sig_out;
    assign fe.sig_out_valid         = r_sig_valid;
    assign fe.start_computation_out = r_start;
    assign fe.overflow_out          = r_overflow;
    assign fe.fifo_level_out        = r_level;
endmodule
`default_nettype wire

// File: tb/tb_yin_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_yin_frontend
// Brief    : Directed self-checking bench for yin_frontend (default build).
// Revision : 1.0
// ============================================================================
module tb_yin_frontend;
    localparam int IN_W  = 12;
    localparam int SIG_W = 9;
    localparam int DEPTH = 64;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    yin_frontend_if #(.IN_WIDTH(IN_W), .SIG_WIDTH(SIG_W), .FIFO_DEPTH(DEPTH)) bus ();

    yin_frontend #(
        .IN_WIDTH(IN_W), .SIG_WIDTH(SIG_W), .DECIM(4),
        .WINDOW_SIZE(500), .HOP(250), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .fe     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cnt_valid = 0;
    int cnt_start = 0;
    int cnt_both  = 0;
    logic [SIG_W-1:0] q_out [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sig_out_valid) begin
                cnt_valid++;
                q_out.push_back(bus.sig_out);
            end
            if (bus.start_computation_out) cnt_start++;
            if (bus.start_computation_out && bus.sig_out_valid) cnt_both++;
        end
    end

    // Sample pattern: signed value for index idx, mapped to an ADC code that decimates exactly to it
    function automatic logic [SIG_W-1:0] sval(input int idx);
        int v;
        v = ((idx * 37) % 512) - 256;
        return v[SIG_W-1:0];
    endfunction

    function automatic logic [IN_W-1:0] sadc(input int idx);
        int v;
        v = 2048 + 8 * (((idx * 37) % 512) - 256);
        return v[IN_W-1:0];
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        bus.adc_in = '0;
        bus.adc_in_valid = 1'b0;
        bus.pitch_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_run(input int n, input int base);
        for (int j = 0; j < n; j++) begin
            for (int p = 0; p < 4; p++) begin
                @(negedge clk);
                bus.adc_in = sadc(base + j);
                bus.adc_in_valid = 1'b1;
            end
        end
        @(negedge clk);
        bus.adc_in_valid = 1'b0;
    endtask

    task automatic push_const(input logic [IN_W-1:0] val, input int n);
        for (int j = 0; j < n * 4; j++) begin
            @(negedge clk);
            bus.adc_in = val;
            bus.adc_in_valid = 1'b1;
        end
        @(negedge clk);
        bus.adc_in_valid = 1'b0;
    endtask

    task automatic pulse_pitch();
        @(negedge clk);
        bus.pitch_valid_in = 1'b1;
        @(negedge clk);
        bus.pitch_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.adc_in = '0;
        bus.adc_in_valid = 1'b0;
        bus.pitch_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.sig_out !== '0) begin bad++; $display("FAIL reset_sig_out: got %0h expected 0", bus.sig_out); end
        total++; if (bus.sig_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.sig_out_valid); end
        total++; if (bus.start_computation_out !== 1'b0) begin bad++; $display("FAIL reset_start: got %b expected 0", bus.start_computation_out); end
        total++; if (bus.overflow_out !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow_out); end
        total++; if (bus.fifo_level_out !== '0) begin bad++; $display("FAIL reset_level: got %0d expected 0", bus.fifo_level_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic conv(input logic [IN_W-1:0] a0, input logic [IN_W-1:0] a1,
                        input logic [IN_W-1:0] a2, input logic [IN_W-1:0] a3,
                        input logic [SIG_W-1:0] expv, input string name);
        logic [IN_W-1:0] vals [4];
        int n;
        vals[0] = a0; vals[1] = a1; vals[2] = a2; vals[3] = a3;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            bus.adc_in = vals[p];
            bus.adc_in_valid = 1'b1;
        end
        @(negedge clk);
        bus.adc_in_valid = 1'b0;
        n = 0;
        while (n < 10 && bus.sig_out_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != 2) begin bad++; $display("FAIL %s_latency: got %0d cycles expected 2", name, n); end
`ifndef FRONTEND_DC_BLOCK_EN
        total++; if (bus.sig_out !== expv) begin bad++; $display("FAIL %s_value: got %0h expected %0h", name, bus.sig_out, expv); end
`endif
    endtask

    task automatic test_conversion();
        conv(12'h800, 12'h800, 12'h800, 12'h800, 9'h000, "conv_mid");
        conv(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 9'h0FF, "conv_max");
        conv(12'h000, 12'h000, 12'h000, 12'h000, 9'h100, "conv_min");
        conv(12'h7F0, 12'h810, 12'h7F0, 12'h810, 9'h000, "conv_mix");
    endtask

    task automatic test_dc();
        int b;
        int errs;
        apply_reset();
        b = q_out.size();
        errs = 0;
`ifdef FRONTEND_DC_BLOCK_EN
        push_const(12'h900, 500);
        repeat (10) @(negedge clk);
        pulse_pitch();
        push_const(12'h900, 100);
        repeat (10) @(negedge clk);
        total++; if (q_out.size() - b != 600) begin bad++; $display("FAIL dc_count: got %0d expected 600", q_out.size() - b); end
        total++; if (q_out[b] !== 9'd32) begin bad++; $display("FAIL dc_first: got %0d expected 32", q_out[b]); end
        for (int j = b + 1; j < q_out.size(); j++)
            if ($signed(q_out[j]) > $signed(q_out[j-1])) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL dc_monotonic: got %0d rises expected 0", errs); end
        total++; if (q_out[q_out.size()-1] !== '0) begin bad++; $display("FAIL dc_final: got %0d expected 0", q_out[q_out.size()-1]); end
`else
        push_const(12'h900, 20);
        repeat (5) @(negedge clk);
        total++; if (q_out.size() - b != 20) begin bad++; $display("FAIL dc_count: got %0d expected 20", q_out.size() - b); end
        for (int j = b; j < q_out.size(); j++)
            if (q_out[j] !== 9'd32) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL dc_const: got %0d wrong samples expected 0", errs); end
`endif
    endtask

    task automatic test_warmup();
        int bv, bs, b, errs;
        apply_reset();
        bv = cnt_valid; bs = cnt_start; b = q_out.size();
        push_run(500, 0);
        repeat (10) @(negedge clk);
        total++; if (cnt_valid - bv != 500) begin bad++; $display("FAIL warmup_valid: got %0d expected 500", cnt_valid - bv); end
        total++; if (cnt_start - bs != 1) begin bad++; $display("FAIL warmup_start: got %0d expected 1", cnt_start - bs); end
        total++; if (cnt_both != 0) begin bad++; $display("FAIL warmup_coincident: got %0d expected 0", cnt_both); end
`ifndef FRONTEND_DC_BLOCK_EN
        errs = 0;
        for (int j = 0; j < 500; j++) if (q_out[b + j] !== sval(j)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL warmup_data: got %0d wrong expected 0", errs); end
`endif
    endtask

    task automatic test_holdoff();
        int bv, bs, b, errs;
        bv = cnt_valid; bs = cnt_start;
        push_run(40, 1000);
        repeat (5) @(negedge clk);
        total++; if (cnt_valid - bv != 0) begin bad++; $display("FAIL holdoff_no_valid: got %0d expected 0", cnt_valid - bv); end
        total++; if (bus.fifo_level_out !== 7'd40) begin bad++; $display("FAIL holdoff_level: got %0d expected 40", bus.fifo_level_out); end
        b = q_out.size();
        pulse_pitch();
        total++; if (bus.sig_out_valid !== 1'b0) begin bad++; $display("FAIL holdoff_first_gap: got %b expected 0", bus.sig_out_valid); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++; if (bus.sig_out_valid !== 1'b1) begin bad++; $display("FAIL holdoff_pop%0d: got %b expected 1", i, bus.sig_out_valid); end
        end
        @(negedge clk);
        total++; if (bus.sig_out_valid !== 1'b0) begin bad++; $display("FAIL holdoff_end: got %b expected 0", bus.sig_out_valid); end
`ifndef FRONTEND_DC_BLOCK_EN
        errs = 0;
        for (int j = 0; j < 40; j++) if (q_out[b + j] !== sval(1000 + j)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL holdoff_data: got %0d wrong expected 0", errs); end
`endif
        push_run(210, 2000);
        repeat (10) @(negedge clk);
        total++; if (cnt_valid - bv != 250) begin bad++; $display("FAIL hop_valid: got %0d expected 250", cnt_valid - bv); end
        total++; if (cnt_start - bs != 1) begin bad++; $display("FAIL hop_start: got %0d expected 1", cnt_start - bs); end
        total++; if (cnt_both != 0) begin bad++; $display("FAIL hop_coincident: got %0d expected 0", cnt_both); end
    endtask

    task automatic test_overflow();
        int bv, b, errs;
        total++; if (bus.overflow_out !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b expected 0", bus.overflow_out); end
        push_run(65, 3000);
        repeat (5) @(negedge clk);
        total++; if (bus.overflow_out !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow_out); end
        total++; if (bus.fifo_level_out !== 7'd64) begin bad++; $display("FAIL ovf_level: got %0d expected 64", bus.fifo_level_out); end
        bv = cnt_valid; b = q_out.size();
        pulse_pitch();
        repeat (80) @(negedge clk);
        total++; if (cnt_valid - bv != 64) begin bad++; $display("FAIL ovf_pops: got %0d expected 64", cnt_valid - bv); end
        total++; if (bus.fifo_level_out !== '0) begin bad++; $display("FAIL ovf_drained: got %0d expected 0", bus.fifo_level_out); end
`ifndef FRONTEND_DC_BLOCK_EN
        errs = 0;
        for (int j = 0; j < 64; j++) if (q_out[b + j] !== sval(3000 + j)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL ovf_order: got %0d wrong expected 0", errs); end
`endif
    endtask

    task automatic test_async_reset();
        int bv, bs;
        bs = cnt_start;
        push_run(186, 4000);
        repeat (10) @(negedge clk);
        total++; if (cnt_start - bs != 1) begin bad++; $display("FAIL ar_pre_start: got %0d expected 1", cnt_start - bs); end
        push_run(20, 5000);
        repeat (5) @(negedge clk);
        total++; if (bus.fifo_level_out !== 7'd20) begin bad++; $display("FAIL ar_pre_level: got %0d expected 20", bus.fifo_level_out); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.sig_out !== '0) begin bad++; $display("FAIL ar_sig_out: got %0h expected 0", bus.sig_out); end
        total++; if (bus.sig_out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b expected 0", bus.sig_out_valid); end
        total++; if (bus.start_computation_out !== 1'b0) begin bad++; $display("FAIL ar_start: got %b expected 0", bus.start_computation_out); end
        total++; if (bus.overflow_out !== 1'b0) begin bad++; $display("FAIL ar_overflow: got %b expected 0", bus.overflow_out); end
        total++; if (bus.fifo_level_out !== '0) begin bad++; $display("FAIL ar_level: got %0d expected 0", bus.fifo_level_out); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bv = cnt_valid; bs = cnt_start;
        push_run(499, 0);
        repeat (10) @(negedge clk);
        total++; if (cnt_start - bs != 0) begin bad++; $display("FAIL ar_no_early_start: got %0d expected 0", cnt_start - bs); end
        total++; if (cnt_valid - bv != 499) begin bad++; $display("FAIL ar_valid_499: got %0d expected 499", cnt_valid - bv); end
        push_run(1, 0);
        repeat (10) @(negedge clk);
        total++; if (cnt_start - bs != 1) begin bad++; $display("FAIL ar_start_500: got %0d expected 1", cnt_start - bs); end
        total++; if (cnt_valid - bv != 500) begin bad++; $display("FAIL ar_valid_500: got %0d expected 500", cnt_valid - bv); end
    endtask

    initial begin
        rst = 1'b1;
        bus.adc_in = '0;
        bus.adc_in_valid = 1'b0;
        bus.pitch_valid_in = 1'b0;
        test_reset();
        test_conversion();
        test_dc();
        test_warmup();
        test_holdoff();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/yin_frontend.md
# yin_frontend

Upstream conditioning and framing stage for the YIN pitch detector. Decimates raw unsigned ADC samples by boxcar averaging, converts them to signed SIG_WIDTH samples, and buffers them in a FIFO. It streams samples into the detector only while the detector is idle, and issues `start_computation` once per hop. A detector result (`f_out_valid`) releases the next batch of samples.

## Interface
- IN_WIDTH, 12, ADC sample width, unsigned, midscale = 2^(IN_WIDTH-1)
- SIG_WIDTH, 9, output sample width, two's complement; must be ≤ IN_WIDTH
- DECIM, 4, decimation factor; power of two, ≥ 2
- WINDOW_SIZE, 500, samples sent before the first start
- HOP, 250, samples sent between subsequent starts
- FIFO_DEPTH, 64, decimated-sample FIFO depth; power of two
- clk_in  in  1  single system clock
- rst_in  in  1  asynchronous, active-high reset
- adc_in  in  IN_WIDTH  raw ADC sample
- adc_in_valid  in  1  one-cycle strobe per ADC sample
- pitch_valid_in  in  1  detector `f_out_valid`; marks the end of a computation
- sig_out  out  SIG_WIDTH  to detector `sig_in`
- sig_out_valid  out  1  to detector `sig_in_valid`
- start_computation_out  out  1  to detector `start_computation`, one-cycle pulse
- overflow_out  out  1  sticky; a decimated sample was dropped
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Decimator:
  - Accumulator width is IN_WIDTH+$clog2(DECIM); a phase counter runs 0..DECIM-1.
  - Each `adc_in_valid` adds the sample to the accumulator.
  - On the DECIM-th sample: mean = sum >> $clog2(DECIM), then offset removal, then arithmetic shift right by IN_WIDTH-SIG_WIDTH, truncated to SIG_WIDTH. The result is registered as a push request; the accumulator clears.
- FIFO:
  - Push the decimated sample if not full, or if a pop occurs in the same cycle.
  - Otherwise drop the newest sample and set `overflow_out`. It is cleared only by reset.
- State machine:
  - States: FILL (warm-up), RUN, WAIT_RESULT, START.
  - FILL and RUN: pop one sample per cycle while the FIFO is non-empty. Register it onto `sig_out` with `sig_out_valid` high for that cycle. Increment `sent_cnt`.
  - FILL → START when `sent_cnt` reaches WINDOW_SIZE. RUN → START when `sent_cnt` reaches HOP. The count is checked after the pop that reaches it.
  - START (1 cycle): `start_computation_out` = 1 and `sig_out_valid` = 0, so start is never coincident with a sample. Clear `sent_cnt`, then go to WAIT_RESULT.
  - WAIT_RESULT: no pops; the FIFO only fills. Go to RUN on `pitch_valid_in`. The first pop happens the cycle after, when the detector is back in IDLE.
  - `pitch_valid_in` outside WAIT_RESULT is ignored.
- `sig_out` holds its last value when `sig_out_valid` = 0.

## Timing
- Reset values:
  - `sig_out` = 0, `sig_out_valid` = 0, `start_computation_out` = 0, `overflow_out` = 0, `fifo_level_out` = 0.
  - State FILL, accumulator/phase/`sent_cnt` = 0, FIFO empty.
- Reset mid-operation discards all buffered samples and returns to FILL, so a full WINDOW_SIZE warm-up is required again.
- Latency from the DECIM-th `adc_in_valid` edge k:
  - FIFO write at edge k+1.
  - `sig_out_valid` registered at edge k+2, when in FILL/RUN with the FIFO empty.
- Throughput: one pop per cycle maximum. ADC strobes may arrive back-to-back.
- Simultaneous push and pop: when full, both succeed and the level is unchanged. When empty, the push lands and the pop occurs the next cycle.
- Pointers wrap modulo FIFO_DEPTH. The level is full-width, so full and empty are distinct.
- `start_computation_out` occurs exactly once per WINDOW_SIZE (first) or HOP (subsequent) samples sent.

## Configuration
- Macro FRONTEND_DC_BLOCK_EN defined:
  - Offset removal uses a tracked DC estimate: dc <= dc + ((mean − dc) >>> 6).
  - The estimate is updated per decimated sample, reset to midscale, and held at IN_WIDTH+6 bits (6 fractional).
  - Output = mean − dc (integer part).
- Macro undefined: offset = fixed midscale 2^(IN_WIDTH-1). There is no DC state.

## Test plan
- Conversion (defaults, no macro):
  - 4× 0x800 → `sig_out` = 0.
  - 4× 0xFFF → 255 (0x0FF).
  - 4× 0x000 → −256 (0x100).
  - 0x7F0,0x810,0x7F0,0x810 → 0.
- Warm-up: 2000 ADC strobes → exactly 500 `sig_out_valid` pulses, then one `start_computation_out` pulse with `sig_out_valid` low, then state WAIT_RESULT.
- Hold-off: in WAIT_RESULT, 40 decimated samples arrive → no `sig_out_valid` and `fifo_level_out` = 40. Then `pitch_valid_in` pulse → 40 pops on consecutive cycles starting the cycle after. The next start comes after 250 total sent.
- Overflow: in WAIT_RESULT, push 65 decimated samples → `overflow_out` = 1 and level = 64. After release, exactly 64 pops, the oldest 64 in order.
- Async reset asserted in WAIT_RESULT with level 20 → all outputs 0 without waiting for a clock edge. After release, 500 samples are required before a start.
- With FRONTEND_DC_BLOCK_EN, constant 0x900 input → `sig_out` starts at 32 and decays monotonically to 0 within 600 decimated samples. Without the macro, the same input → a constant 32.
